// File: rtl/io_display_ctrl.sv
// Seven-segment display controller for the processor I/O path: shows num or the
// switch value in hex or decimal, using a sequential shift-add-3 BCD converter.
module io_display_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned SW_WIDTH    = 4,
  parameter bit          BLANK_ZEROS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic [DATA_WIDTH-1:0] num,
  input  logic                  output_flag,
  input  logic                  input_flag,
  input  logic                  hex_mode,
  input  logic                  signed_mode,
  input  logic [SW_WIDTH-1:0]   SW,
  output logic [DATA_WIDTH-1:0] user_input,
  output logic                  busy,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int unsigned BCD_DIGITS = 10;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W      = $clog2(DATA_WIDTH + 1);
  localparam int unsigned HEX_PAD    = (DATA_WIDTH > 4 * DIGITS) ? DATA_WIDTH : 4 * DIGITS;

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_ZERO  = 7'b1000000;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mag_r;
  logic                  hex_r;
  logic                  sign_r;
  logic [BCD_W-1:0]      bcd;
  logic [CNT_W-1:0]      cnt;

  logic [DATA_WIDTH-1:0] src;
  logic                  src_neg;
  logic [DATA_WIDTH-1:0] src_mag;
  logic [HEX_PAD-1:0]    hex_val;
  logic [7*DIGITS-1:0]   hex_disp;
  logic [7*DIGITS-1:0]   dec_disp;
  int unsigned           msd;
  int unsigned           sign_pos;
  logic                  dec_ovf;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // One double-dabble step: correct every nibble >= 5, then shift in the next bit.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] b,
                                                   input logic bit_in);
    logic [BCD_W-1:0] r;
    r = b;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    r = (r << 1) | BCD_W'(bit_in);
    return r;
  endfunction

  assign user_input = DATA_WIDTH'(SW);

  always_comb begin
    src     = output_flag ? num : user_input;
    src_neg = signed_mode & num[DATA_WIDTH-1] & output_flag & ~hex_mode;
    src_mag = src_neg ? -src : src;
  end

  always_comb begin
    hex_disp = '1;
    hex_val  = HEX_PAD'(mag_r);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      hex_disp[7*i +: 7] = glyph(hex_val[4*i +: 4]);
    end
  end

  always_comb begin
    msd      = 0;
    sign_pos = 0;
    dec_ovf  = 1'b0;
    dec_disp = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    end
    for (int unsigned i = DIGITS; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) dec_ovf = 1'b1;
    end
    sign_pos = BLANK_ZEROS ? msd + 1 : DIGITS - 1;
    // A negative value also overflows when the sign digit collides with the magnitude.
    if (sign_r && (sign_pos >= DIGITS || msd >= sign_pos)) dec_ovf = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sign_r && i == sign_pos)       dec_disp[7*i +: 7] = GLYPH_DASH;
      else if (!BLANK_ZEROS || i <= msd) dec_disp[7*i +: 7] = glyph(bcd[4*i +: 4]);
      else                               dec_disp[7*i +: 7] = GLYPH_BLANK;
    end
    if (dec_ovf) begin
      dec_disp                    = '1;
      dec_disp[7*(DIGITS-1) +: 7] = GLYPH_E;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      hex_out <= '1;
      mag_r   <= '0;
      hex_r   <= 1'b0;
      sign_r  <= 1'b0;
      bcd     <= '0;
      cnt     <= '0;
    end else if (halt) begin
      state   <= IDLE;
      busy    <= 1'b0;
      hex_out <= '1;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (output_flag ^ input_flag) begin
            if (input_flag && user_input == '0) begin
              hex_out <= {DIGITS{GLYPH_DASH}};
            end else begin
              mag_r  <= src_mag;
              hex_r  <= hex_mode;
              sign_r <= src_neg;
              bcd    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= hex_mode ? LOAD : CONV;
            end
          end else begin
            hex_out <= {DIGITS{GLYPH_ZERO}};
          end
        end
        CONV: begin
          bcd   <= dabble_step(bcd, mag_r[DATA_WIDTH-1]);
          mag_r <= mag_r << 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_WIDTH - 1)) state <= LOAD;
        end
        LOAD: begin
          hex_out <= hex_r ? hex_disp : dec_disp;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_display_ctrl.sv
// Scoreboard bench for io_display_ctrl: stimulus queues expected display words
// with their due cycle; the monitor checks each display update against them.
module tb_io_display_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic [31:0] num;
  logic        output_flag;
  logic        input_flag;
  logic        hex_mode;
  logic        signed_mode;
  logic [3:0]  sw;
  logic [31:0] user_input;
  logic        busy;
  logic [55:0] hex_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    string       name;
    logic [55:0] val;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [55:0] prev = '1;

  io_display_ctrl #(
    .DATA_WIDTH (32),
    .DIGITS     (8),
    .SW_WIDTH   (4),
    .BLANK_ZEROS(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .num        (num),
    .output_flag(output_flag),
    .input_flag (input_flag),
    .hex_mode   (hex_mode),
    .signed_mode(signed_mode),
    .SW         (sw),
    .user_input (user_input),
    .busy       (busy),
    .hex_out    (hex_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Display pattern written left to right: character 0 is digit 7.
  function automatic logic [55:0] disp(input string s);
    logic [55:0] r;
    logic [6:0]  g;
    byte         c;
    r = '1;
    for (int k = 0; k < 8; k++) begin
      c = s[k];
      case (c)
        "0": g = 7'b1000000;
        "1": g = 7'b1111001;
        "2": g = 7'b0100100;
        "3": g = 7'b0110000;
        "4": g = 7'b0011001;
        "5": g = 7'b0010010;
        "6": g = 7'b0000010;
        "7": g = 7'b1111000;
        "8": g = 7'b0000000;
        "9": g = 7'b0010000;
        "A": g = 7'b0001000;
        "B": g = 7'b0000011;
        "C": g = 7'b1000110;
        "D": g = 7'b0100001;
        "E": g = 7'b0000110;
        "F": g = 7'b0001110;
        "-": g = 7'b0111111;
        default: g = 7'b1111111;
      endcase
      r[7*(7-k) +: 7] = g;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev = hex_out;
    end else if (hex_out !== prev) begin
      prev = hex_out;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update got=%h at cycle %0d", hex_out, cyc);
      end else begin
        e = sb.pop_front();
        if (hex_out !== e.val || cyc != e.due) begin
          errors++;
          $display("FAIL %s got=%h@%0d want=%h@%0d", e.name, hex_out, cyc, e.val, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic apply(input logic o, input logic i, input logic h, input logic s,
                       input logic [31:0] n, input logic [3:0] w);
    output_flag = o;
    input_flag  = i;
    hex_mode    = h;
    signed_mode = s;
    num         = n;
    sw          = w;
    halt        = 1'b0;
  endtask

  task automatic expect_at(input string name, input string pat, input int lat);
    exp_t e;
    e.name = name;
    e.val  = disp(pat);
    e.due  = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout pending=%0d", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic halt_pulse();
    @(negedge clk);
    halt = 1'b1;
    expect_at("halt_blank", "        ", 1);
  endtask

  task automatic run(input string name, input logic o, input logic i, input logic h,
                     input logic s, input logic [31:0] n, input logic [3:0] w,
                     input string pat, input int lat);
    @(negedge clk);
    apply(o, i, h, s, n, w);
    expect_at(name, pat, lat);
    wait_drain(name);
    halt_pulse();
  endtask

  initial begin
    int bc;
    int n;
    reset = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("reset_hex_lo", hex_out[31:0], 32'hFFFFFFFF);
    check("reset_hex_hi", {8'h0, hex_out[55:32]}, 32'h00FFFFFF);
    check("reset_busy", {31'd0, busy}, 32'd0);
    output_flag = 1'b1;
    reset = 1'b0;

    // Decimal 12345: busy for 33 sampled cycles, result 34 cycles after setup.
    num = 32'd12345;
    expect_at("dec_12345", "   12345", 34);
    bc = 0;
    n  = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      bc++;
      n++;
      @(negedge clk);
    end
    check("dec_busy_len", bc, 33);
    wait_drain("dec_12345");
    halt_pulse();

    @(negedge clk);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'd0);
    expect_at("hex_deadbeef", "DEADBEEF", 2);
    @(negedge clk);
    check("hex_busy_hi", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("hex_busy_lo", {31'd0, busy}, 32'd0);
    wait_drain("hex_deadbeef");
    halt_pulse();

    run("dec_neg42",   1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFD6,           4'd0, "     -42", 34);
    run("ovf_9digit",  1'b1, 1'b0, 1'b0, 1'b0, 32'd100000000,          4'd0, "E       ", 34);
    run("ovf_minint",  1'b1, 1'b0, 1'b0, 1'b1, 32'h80000000,           4'd0, "E       ", 34);
    run("dec_max8",    1'b1, 1'b0, 1'b0, 1'b0, 32'd99999999,           4'd0, "99999999", 34);
    run("dec_neg7",    1'b1, 1'b0, 1'b0, 1'b1, 32'd0 - 32'd9999999,    4'd0, "-9999999", 34);
    run("ovf_neg8",    1'b1, 1'b0, 1'b0, 1'b1, 32'd0 - 32'd10000000,   4'd0, "E       ", 34);
    run("dec_zero",    1'b1, 1'b0, 1'b0, 1'b1, 32'd0,                  4'd0, "       0", 34);
    run("hex_nosign",  1'b1, 1'b0, 1'b1, 1'b1, 32'h8000001F,           4'd0, "8000001F", 2);

    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0);
    expect_at("sw_zero_dash", "--------", 1);
    @(negedge clk);
    check("sw_zero_busy0", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("sw_zero_busy1", {31'd0, busy}, 32'd0);
    wait_drain("sw_zero_dash");
    halt_pulse();

    @(negedge clk);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 32'h80000000, 4'b1001);
    check("user_input_9", user_input, 32'd9);
    expect_at("sw_nine", "       9", 34);
    wait_drain("sw_nine");
    halt_pulse();

    run("neither_zero", 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 4'd3, "00000000", 1);

    // Halt ten cycles into a conversion, then let the held flag restart it.
    @(negedge clk);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32'd777, 4'd0);
    expect_at("both_zero", "00000000", 1);
    wait_drain("both_zero");
    @(negedge clk);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'd777, 4'd0);
    repeat (9) @(negedge clk);
    check("conv_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    halt = 1'b1;
    expect_at("halt_abort", "        ", 1);
    @(negedge clk);
    check("halt_busy0", {31'd0, busy}, 32'd0);
    halt = 1'b0;
    expect_at("restart_777", "     777", 34);
    wait_drain("restart_777");
    halt_pulse();

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0);
    expect_at("both_zero2", "00000000", 1);
    wait_drain("both_zero2");
    @(negedge clk);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'd12345, 4'd0);
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_lo", hex_out[31:0], 32'hFFFFFFFF);
    check("async_rst_hi", {8'h0, hex_out[55:32]}, 32'h00FFFFFF);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    #2 reset = 1'b0;
    expect_at("post_reset_zero", "00000000", 1);
    wait_drain("post_reset_zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
